// File: rtl/inst_fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, the nop instruction and the sequential PC step.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/inst_fetch_next_pc_gen.sv
// Combinational next-PC selection for the retiring instruction: jalr > jal > conditional branch > pc+4.
module next_pc_gen
  import inst_fetch_pkg::*;
(
  input  logic        beq,
  input  logic        bne,
  input  logic        blt,
  input  logic        bge,
  input  logic        bltu,
  input  logic        bgeu,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic [31:0] inst_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] next_pc
);

  logic        taken;
  logic [31:0] jalr_sum;

  always_comb begin
    taken    = (beq & zero) | (bne & ~zero) | (blt & lt) | (bge & ~lt) |
               (bltu & ltu) | (bgeu & ~ltu);
    jalr_sum = rs1_data + imm;
    if (jalr)
      next_pc = jalr_sum & ~32'h1;
    else if (jal || taken)
      next_pc = inst_pc + imm;
    else
      next_pc = inst_pc + PC_STEP;
  end

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit with request/ready/rvalid memory handshake.
// Optional misaligned-target trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        beq,
  input  logic        bne,
  input  logic        blt,
  input  logic        bge,
  input  logic        bltu,
  input  logic        bgeu,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  next_pc;
  logic [31:0]  pc_target;
  logic         misaligned;
  logic         capture;
  logic         retire;
  logic         req_c;

  next_pc_gen u_next_pc_gen (
    .beq      (beq),
    .bne      (bne),
    .blt      (blt),
    .bge      (bge),
    .bltu     (bltu),
    .bgeu     (bgeu),
    .jal      (jal),
    .jalr     (jalr),
    .zero     (zero),
    .lt       (lt),
    .ltu      (ltu),
    .inst_pc  (inst_pc),
    .imm      (imm),
    .rs1_data (rs1_data),
    .next_pc  (next_pc)
  );

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign pc_target   = next_pc;
  assign misaligned  = |next_pc[1:0];
  assign fetch_fault = (state_q == ST_FAULT);
`else
  // Without the trap, targets are silently word-aligned.
  assign pc_target   = next_pc & ~32'h3;
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    retire  = 1'b0;
    req_c   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_c = 1'b1;
        if (imem_ready) begin
          if (imem_rvalid) begin
            capture = 1'b1;
            state_d = ST_VALID;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (inst_ready) begin
          retire  = 1'b1;
          state_d = misaligned ? ST_FAULT : ST_FETCH;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_FETCH;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst    <= NOP_INST;
      inst_pc <= RESET_PC;
    end else begin
      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= pc_q;
      end
      if (retire)
        pc_q <= pc_target;
    end
  end

  // State resets to FETCH, so the request must also be masked while rst_n is low.
  assign imem_req   = req_c & rst_n;
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == ST_VALID);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: handshake timing, next-PC selection, wrap and async reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        beq, bne, blt, bge, bltu, bgeu, jal, jalr;
  logic        zero, lt, ltu;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [7:0] F_NONE = 8'b0000_0000;
  localparam logic [7:0] F_BEQ  = 8'b1000_0000;
  localparam logic [7:0] F_BGE  = 8'b0001_0000;
  localparam logic [7:0] F_BLTU = 8'b0000_1000;
  localparam logic [7:0] F_JAL  = 8'b0000_0010;
  localparam logic [7:0] F_JALR = 8'b0000_0001;
  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_Z    = 3'b100;
  localparam logic [2:0] C_LT   = 3'b010;
  localparam logic [2:0] C_LTU  = 3'b001;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .beq         (beq),
    .bne         (bne),
    .blt         (blt),
    .bge         (bge),
    .bltu        (bltu),
    .bgeu        (bgeu),
    .jal         (jal),
    .jalr        (jalr),
    .zero        (zero),
    .lt          (lt),
    .ltu         (ltu),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_ctrl(input logic [7:0] fl, input logic [2:0] cmp,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v);
    {beq, bne, blt, bge, bltu, bgeu, jal, jalr} = fl;
    {zero, lt, ltu} = cmp;
    imm      = imm_v;
    rs1_data = rs1_v;
  endtask

  // Called just after a negedge with the DUT in FETCH; returns one negedge later in VALID.
  task automatic fetch_zero_wait(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"}, inst, word);
    check({tag, "_ipc"}, inst_pc, exp_addr);
  endtask

  // Control inputs are held only for the retire cycle, then scrambled to prove they are not sampled later.
  task automatic retire(input logic [7:0] fl, input logic [2:0] cmp,
                        input logic [31:0] imm_v, input logic [31:0] rs1_v);
    set_ctrl(fl, cmp, imm_v, rs1_v);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    set_ctrl(F_JALR, 3'b111, 32'h5555_5555, 32'hAAAA_AAA8);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_ipc", inst_pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;
    set_ctrl(F_NONE, C_NONE, 32'h0, 32'h0);
    @(negedge clk);
    apply_reset();

    // Zero-wait fetch of addi x1,x0,5 then sequential retire
    fetch_zero_wait("t1", 32'h0, 32'h0050_0093);
    check("t1_req_in_valid", 32'(imem_req), 32'd0);
    retire(F_NONE, C_NONE, 32'h0, 32'h0);
    check("t1_next_req", 32'(imem_req), 32'd1);
    check("t1_next_addr", imem_addr, 32'h4);
    check("t1_valid_clr", 32'(inst_valid), 32'd0);

    // Late grant with a stray rvalid, then rvalid two cycles after grant
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      check("t2_req_held", 32'(imem_req), 32'd1);
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("t2_no_valid", 32'(inst_valid), 32'd0);
    end
    check("t2_req_4th", 32'(imem_req), 32'd1);
    check("t2_addr", imem_addr, 32'h4);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check("t2_wait_req", 32'(imem_req), 32'd0);
    check("t2_wait_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("t2_wait2_valid", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t2_valid", 32'(inst_valid), 32'd1);
    check("t2_inst", inst, 32'hDEAD_BEEF);
    check("t2_ipc", inst_pc, 32'h4);
    imem_rdata = 32'h2222_2222;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("t2_stall_valid", 32'(inst_valid), 32'd1);
    check("t2_stall_inst", inst, 32'hDEAD_BEEF);

    // jal to 0x100, then beq taken / not taken
    retire(F_JAL, C_NONE, 32'h0000_00FC, 32'h0);
    fetch_zero_wait("t3a", 32'h100, 32'hFE00_0CE3);
    retire(F_BEQ, C_Z, 32'hFFFF_FFF8, 32'h0);
    fetch_zero_wait("t3b", 32'h0F8, 32'h0080_006F);
    retire(F_JAL, C_NONE, 32'h8, 32'h0);
    fetch_zero_wait("t3c", 32'h100, 32'hFE00_0CE3);
    retire(F_BEQ, C_NONE, 32'hFFFF_FFF8, 32'h0);
    fetch_zero_wait("t3d", 32'h104, 32'h0200_6063);
    retire(F_BLTU, C_LTU, 32'h20, 32'h0);
    fetch_zero_wait("t3e", 32'h124, 32'h0400_5063);
    retire(F_BGE, C_LT, 32'h40, 32'h0);

    // jalr clears bit 0 and wins over jal and a taken branch
    fetch_zero_wait("t4a", 32'h128, 32'h0042_8067);
    retire(F_JALR | F_JAL | F_BEQ, C_Z, 32'h4, 32'h0000_2001);
    fetch_zero_wait("t4b", 32'h2004, 32'h0041_0067);
    retire(F_JALR, C_NONE, 32'h4, 32'hFFFF_FFF8);

    // Sequential step from the top of the address space wraps to 0
    fetch_zero_wait("t5", 32'hFFFF_FFFC, 32'h0000_0013);
    retire(F_NONE, C_NONE, 32'h0, 32'h0);
    fetch_zero_wait("t5w", 32'h0, 32'h0001_0067);

    // jalr to a misaligned target
    retire(F_JALR, C_NONE, 32'h0, 32'h0000_2002);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("t6_fault", 32'(fetch_fault), 32'd1);
    check("t6_req", 32'(imem_req), 32'd0);
    check("t6_valid", 32'(inst_valid), 32'd0);
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    check("t6_fault_hold", 32'(fetch_fault), 32'd1);
    check("t6_req_hold", 32'(imem_req), 32'd0);
`else
    check("t6_fault", 32'(fetch_fault), 32'd0);
    check("t6_addr", imem_addr, 32'h2000);
    check("t6_req", 32'(imem_req), 32'd1);
`endif

    // Reset while a transaction is outstanding in WAIT
    apply_reset();
    fetch_zero_wait("t7a", 32'h0, 32'h00A0_0113);
    retire(F_NONE, C_NONE, 32'h0, 32'h0);
    check("t7_addr4", imem_addr, 32'h4);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check("t7_in_wait", 32'(imem_req), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_req", 32'(imem_req), 32'd0);
    check("t7_rst_addr", imem_addr, 32'h0);
    check("t7_rst_inst", inst, 32'h0000_0013);
    check("t7_rst_ipc", inst_pc, 32'h0);
    check("t7_rst_valid", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3333_3333;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("t7_rst_hold_req", 32'(imem_req), 32'd0);
    check("t7_rst_hold_valid", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    fetch_zero_wait("t7b", 32'h0, 32'h0050_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports, one clock; reset asynchronous, active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ready  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst/inst_pc valid to decode
- inst  out  32  held instruction
- inst_pc  out  32  PC of held instruction
- inst_ready  in  1  execute retires held instruction this cycle
- beq, bne, blt, bge, bltu, bgeu, jal, jalr  in  1 each  decoded control-flow flags from main controller
- zero, lt, ltu  in  1 each  ALU compare flags for rs1-rs2
- imm  in  32  sign-extended immediate
- rs1_data  in  32  rs1 value, jalr base
- fetch_fault  out  1  misaligned-target fault (macro only, else tied 0)

Function
REQ-003 SHALL implement FSM states FETCH, WAIT, VALID, FAULT; one-hot or binary encoding is free.
REQ-004 FETCH: imem_req=1, imem_addr=pc; imem_ready=0 -> stay; imem_ready=1 and imem_rvalid=0 -> WAIT; both 1 -> capture, VALID next cycle.
REQ-005 WAIT: imem_req=0; imem_rvalid=1 -> capture imem_rdata into inst, pc into inst_pc, go VALID.
REQ-006 imem_rvalid SHALL be ignored in FETCH (without same-cycle imem_ready), VALID and FAULT.
REQ-007 VALID: inst_valid=1, inst/inst_pc stable; inst_ready=0 -> stay; inst_ready=1 -> pc<=next_pc, go FETCH.
REQ-008 Latency: imem_req reasserted the cycle after retire; zero-wait memory gives one instruction per 2 cycles.
REQ-009 Taken SHALL be: beq&zero | bne&~zero | blt&lt | bge&~lt | bltu&ltu | bgeu&~ltu.
REQ-010 next_pc SHALL be: jalr -> (rs1_data+imm)&~32'h1; jal or taken -> inst_pc+imm; else inst_pc+4.
REQ-011 All PC adds SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-012 Control-flow inputs SHALL be sampled only in the VALID&inst_ready cycle.
REQ-013 Multiple flags asserted: priority jalr > jal > branch.

Reset
REQ-014 rst_n low SHALL asynchronously force: state FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_pc=RESET_PC, inst_valid=0, fetch_fault=0.
REQ-015 During reset imem_req SHALL be 0; first request in first clock edge after rst_n deasserts.
REQ-016 Reset mid-WAIT abandons the transaction; instruction memory shares rst_n and drops its response.

Configuration
REQ-017 IFETCH_MISALIGN_TRAP_EN defined: next_pc[1:0]!=0 at retire -> FAULT, pc<=next_pc, fetch_fault=1, imem_req=0; leave FAULT only by reset.
REQ-018 IFETCH_MISALIGN_TRAP_EN undefined: next_pc[1:0] forced to 2'b00, FAULT unreachable, fetch_fault tied 0.

Structure
REQ-019 FSM state encodings and nop constant SHALL reside in shared parameters.v with existing opcode defines; RESET_PC stays a module parameter.
REQ-020 Next-PC logic SHALL be a combinational sub-module next_pc_gen (inputs: flags, compare bits, inst_pc, imm, rs1_data; output next_pc).

Verification
REQ-021 Reset, RESET_PC=0, imem_ready=imem_rvalid=1 same cycle, rdata=32'h00500093 -> inst_valid=1 cycle 2, inst_pc=0; inst_ready=1 -> imem_addr=4.
REQ-022 imem_ready 3 cycles late, rvalid 2 cycles after grant -> imem_req held 4 cycles, inst_valid only after rvalid, stray rvalid in FETCH ignored.
REQ-023 inst_pc=0x100, beq, zero=1, imm=-8 -> next fetch 0x0F8; same with zero=0 -> 0x104.
REQ-024 jalr, rs1_data=0x2001, imm=4 -> fetch 0x2004; with macro and rs1_data=0x2002 -> FAULT, fetch_fault=1, no imem_req.
REQ-025 inst_pc=0xFFFF_FFFC, no branch, retire -> imem_addr=0x0.
REQ-026 rst_n pulsed low in WAIT -> outputs reset values immediately; first request to RESET_PC after release.
